pc_branch_seq: RTL and testbench
================================

// Module: pc_branch_seq
// PURPOSE
//   Program-counter sequencer for the control-flow opcodes the control unit decodes (JMP, CALL, RET,
//   GOTO, JZ, JNZ), plus plain sequential increment. Owns the PC register and a return-address stack.
//   Sits beside the control unit: the UC issues one branch op at a time over a valid/ready handshake
//   and pulses pc_inc after each ALU instruction. The PC drives instruction fetch.
// PARAMETERS
//   ADDR_W       8   PC / target / return-address width
//   STACK_DEPTH  8   return-stack entries (>=1)
//   RESET_PC     0   PC value loaded on reset
// PORTS
//   clock      in   1                           single clock; all state updates on posedge
//   reset      in   1                           asynchronous, active-low; 0 = reset asserted
//   op_valid   in   1                           branch op request from UC
//   op_ready   out  1                           1 only in IDLE; op accepted when op_valid & op_ready
//   opcode     in   8                           0x81 JMP, 0x82 CALL, 0x83 RET, 0x84 GOTO, 0x85 JZ, 0x87 JNZ
//   target     in   ADDR_W                      branch/call destination, sampled at accept
//   zero_flag  in   1                           ALU zero flag, sampled at accept
//   pc_inc     in   1                           sequential advance request (PC+1)
//   pc         out  ADDR_W                      current program counter
//   done       out  1                           one-cycle pulse: op complete, PC final
//   taken      out  1                           valid with done: 1 if PC loaded from target/stack
//   sp         out  $clog2(STACK_DEPTH+1)       stack occupancy, 0..STACK_DEPTH
//   stack_ovf  out  1                           sticky: CALL issued with full stack
//   stack_unf  out  1                           sticky: RET issued with empty stack
// BEHAVIOUR
//   Reset (reset=0, async): pc=RESET_PC, sp=0, state=IDLE, done=taken=0, ovf=unf=0. Stack RAM not
//   cleared (contents don't-care). Reset mid-op aborts the op; no done pulse.
//   States: IDLE, EXEC, LOAD, DONE.
//   IDLE: op_ready=1. On accept: latch opcode, target, zero_flag; -> EXEC; pc_inc that cycle ignored.
//     Else if pc_inc: pc <= pc+1 (mod 2^ADDR_W). pc_inc ignored in all other states.
//   EXEC (one cycle, by latched opcode):
//     JMP/GOTO: pc<=target, taken<=1 -> DONE.
//     JZ: zero=1 -> pc<=target, taken<=1; else pc<=pc+1 -> DONE. JNZ: inverse condition.
//     CALL: sp<STACK_DEPTH -> stack[sp]<=pc+1 (wrapped), sp<=sp+1 -> LOAD;
//           full -> stack_ovf<=1, pc<=pc+1, no push, taken=0 -> DONE.
//     RET: sp>0 -> sp<=sp-1 -> LOAD; empty -> stack_unf<=1, pc<=pc+1, taken=0 -> DONE.
//     Any other opcode: NOP, pc<=pc+1, taken=0 -> DONE.
//   LOAD: CALL -> pc<=latched target; RET -> pc<=stack[sp] (already-decremented sp); taken<=1 -> DONE.
//   DONE: done=1 for exactly one cycle, taken held; -> IDLE. taken cleared on leaving DONE.
//   Latency (accept edge = T0): JMP/GOTO/JZ/JNZ/NOP: pc updated at T1, done high cycle after T1
//     (2 cycles accept->done). CALL/RET success: push/pop at T1, pc at T2, done after T2 (3 cycles).
//   Stack is LIFO; nested CALLs up to STACK_DEPTH return in reverse order. Full-stack CALL and
//     empty-stack RET never corrupt sp or stack entries.
//   Sticky flags clear only on reset. op_valid ignored outside IDLE; UC holds it until accepted.
// TESTING
//   1. Reset low mid-CALL (state LOAD) -> pc=RESET_PC, sp=0, no done; release, pc_inc x3 -> pc=3.
//   2. pc=0x10, JMP target 0x40 -> op_ready low 2 cycles, pc=0x40 at T1, done&taken next cycle.
//   3. JZ target 0x20 with zero=0 at pc=0x05 -> pc=0x06, taken=0; same with zero=1 -> pc=0x20, taken=1;
//      JNZ mirrors.
//   4. pc=0x10 CALL 0x80, then CALL 0x90 at pc=0x80 -> sp=2; RET -> pc=0x81, RET -> pc=0x11, sp=0.
//   5. Fill stack with 8 CALLs, 9th CALL -> stack_ovf=1, sp=8, pc=pc+1; RET at sp=0 -> stack_unf=1.
//   6. pc=0xFF pc_inc -> 0x00; CALL at pc=0xFF -> stored return 0x00; op_valid&pc_inc same cycle ->
//      op accepted, no extra increment.

Source files
------------

// File: rtl/pc_branch_seq.sv
// ============================================================================
// pc_branch_seq
// ----------------------------------------------------------------------------
// Program-counter sequencer for the control-flow opcodes issued by the control
// unit (JMP, CALL, RET, GOTO, JZ, JNZ), plus plain sequential increment.
// Owns the program counter and a LIFO return-address stack.
//
// Operation
//   The control unit hands over one branch op at a time with a valid/ready
//   handshake. Between ops, pc_inc advances the PC by one. Each accepted op
//   ends with a single-cycle 'done' pulse; 'taken' is valid alongside 'done'
//   and shows whether the PC was loaded from the target or from the stack.
//
// Parameters
//   ADDR_W       PC / target / return-address width
//   STACK_DEPTH  number of return-stack entries (>= 1)
//   RESET_PC     PC value loaded on reset
//
// Ports
//   clock      in   single clock, all state changes on the rising edge
//   reset      in   asynchronous, active-low (0 = reset asserted)
//   op_valid   in   branch op request from the control unit
//   op_ready   out  high only while idle; op accepted on op_valid & op_ready
//   opcode     in   0x81 JMP, 0x82 CALL, 0x83 RET, 0x84 GOTO, 0x85 JZ,
//                   0x87 JNZ; anything else executes as a NOP
//   target     in   branch/call destination, sampled at accept
//   zero_flag  in   ALU zero flag, sampled at accept
//   pc_inc     in   sequential advance request (PC+1), honoured only in idle
//   pc         out  current program counter
//   done       out  one-cycle pulse: op complete, PC holds its final value
//   taken      out  valid with done: PC was loaded from target or stack
//   sp         out  stack occupancy, 0..STACK_DEPTH
//   stack_ovf  out  sticky: CALL issued while the stack was full
//   stack_unf  out  sticky: RET issued while the stack was empty
// ============================================================================
module pc_branch_seq #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               op_valid,
    output logic                               op_ready,
    input  logic [7:0]                         opcode,
    input  logic [ADDR_W-1:0]                  target,
    input  logic                               zero_flag,
    input  logic                               pc_inc,
    output logic [ADDR_W-1:0]                  pc,
    output logic                               done,
    output logic                               taken,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               stack_ovf,
    output logic                               stack_unf
);

    // ------------------------------------------------------------------------
    // Local sizes and constants
    // ------------------------------------------------------------------------
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    // A one-entry stack still needs a one-bit index.
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0]   SP_EMPTY = '0;
    localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);

    localparam logic [7:0] OP_JMP  = 8'h81;
    localparam logic [7:0] OP_CALL = 8'h82;
    localparam logic [7:0] OP_RET  = 8'h83;
    localparam logic [7:0] OP_GOTO = 8'h84;
    localparam logic [7:0] OP_JZ   = 8'h85;
    localparam logic [7:0] OP_JNZ  = 8'h87;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [7:0]          r_op;
    logic [ADDR_W-1:0]   r_target;
    logic                r_zero;
    logic [ADDR_W-1:0]   r_pc;
    logic [SP_W-1:0]     r_sp;
    logic                r_done;
    logic                r_taken;
    logic                r_ovf;
    logic                r_unf;

    // Return-address storage; deliberately not reset so it can map onto RAM.
    logic [ADDR_W-1:0]   r_stack [STACK_DEPTH];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                w_accept;
    logic [ADDR_W-1:0]   w_pcPlus1;
    logic                w_stackFull;
    logic                w_stackEmpty;
    logic                w_push;
    logic [IDX_W-1:0]    w_spIdx;
    logic [ADDR_W-1:0]   w_popData;

    assign w_accept     = op_valid && (r_state == IDLE);
    // Natural wrap modulo 2^ADDR_W, so a CALL at the top address returns to 0.
    assign w_pcPlus1    = r_pc + 1'b1;
    assign w_stackFull  = (r_sp == SP_FULL);
    assign w_stackEmpty = (r_sp == SP_EMPTY);
    // Push happens at the EXEC edge, into the slot the current sp points at.
    assign w_push       = (r_state == EXEC) && (r_op == OP_CALL) && !w_stackFull;
    // sp never exceeds STACK_DEPTH-1 whenever it is used as an index: pushes
    // only happen when not full, and pops read after the decrement.
    assign w_spIdx      = r_sp[IDX_W-1:0];
    assign w_popData    = r_stack[w_spIdx];

    // ------------------------------------------------------------------------
    // Return stack write port. A full-stack CALL never reaches here, so the
    // existing entries are never overwritten on overflow.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_stack[w_spIdx] <= w_pcPlus1;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM. IDLE accepts ops or handles pc_inc; EXEC resolves the
    // op in one cycle; LOAD is the extra cycle CALL/RET need so the stack
    // read/write settles before the PC is reloaded; DONE emits the one-cycle
    // done pulse with taken held alongside it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_target <= '0;
            r_zero   <= 1'b0;
            r_pc     <= PC_INIT;
            r_sp     <= '0;
            r_done   <= 1'b0;
            r_taken  <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done  <= 1'b0;
                    r_taken <= 1'b0;
                    if (w_accept) begin
                        // An op wins over a simultaneous pc_inc.
                        r_op     <= opcode;
                        r_target <= target;
                        r_zero   <= zero_flag;
                        r_state  <= EXEC;
                    end else if (pc_inc) begin
                        r_pc <= w_pcPlus1;
                    end
                end

                EXEC: begin
                    case (r_op)
                        OP_JMP, OP_GOTO: begin
                            r_pc    <= r_target;
                            r_taken <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                        OP_JZ, OP_JNZ: begin
                            // JZ branches on zero, JNZ on non-zero.
                            if (r_zero == (r_op == OP_JZ)) begin
                                r_pc    <= r_target;
                                r_taken <= 1'b1;
                            end else begin
                                r_pc    <= w_pcPlus1;
                                r_taken <= 1'b0;
                            end
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                        OP_CALL: begin
                            if (!w_stackFull) begin
                                r_sp    <= r_sp + 1'b1;
                                r_state <= LOAD;
                            end else begin
                                r_ovf   <= 1'b1;
                                r_pc    <= w_pcPlus1;
                                r_taken <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end
                        end
                        OP_RET: begin
                            if (!w_stackEmpty) begin
                                r_sp    <= r_sp - 1'b1;
                                r_state <= LOAD;
                            end else begin
                                r_unf   <= 1'b1;
                                r_pc    <= w_pcPlus1;
                                r_taken <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end
                        end
                        default: begin
                            // Unknown opcodes behave as a NOP that still
                            // completes the handshake.
                            r_pc    <= w_pcPlus1;
                            r_taken <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    endcase
                end

                LOAD: begin
                    // Only CALL and RET reach LOAD. For RET, sp has already
                    // been decremented so it points at the top entry.
                    if (r_op == OP_CALL) begin
                        r_pc <= r_target;
                    end else begin
                        r_pc <= w_popData;
                    end
                    r_taken <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_taken <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_taken <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign op_ready  = (r_state == IDLE);
    assign pc        = r_pc;
    assign done      = r_done;
    assign taken     = r_taken;
    assign sp        = r_sp;
    assign stack_ovf = r_ovf;
    assign stack_unf = r_unf;

endmodule

// File: tb/tb_pc_branch_seq.sv
// ============================================================================
// tb_pc_branch_seq
// ----------------------------------------------------------------------------
// Directed bench for pc_branch_seq with hand-computed expected values.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ============================================================================
module tb_pc_branch_seq;

    localparam int ADDR_W      = 8;
    localparam int STACK_DEPTH = 8;
    localparam int SP_W        = $clog2(STACK_DEPTH + 1);

    localparam logic [7:0] JMP  = 8'h81;
    localparam logic [7:0] CALL = 8'h82;
    localparam logic [7:0] RET  = 8'h83;
    localparam logic [7:0] GOTO = 8'h84;
    localparam logic [7:0] JZ   = 8'h85;
    localparam logic [7:0] JNZ  = 8'h87;
    localparam logic [7:0] NOPC = 8'h86;

    logic               clock;
    logic               reset;
    logic               op_valid;
    logic               op_ready;
    logic [7:0]         opcode;
    logic [ADDR_W-1:0]  target;
    logic               zero_flag;
    logic               pc_inc;
    logic [ADDR_W-1:0]  pc;
    logic               done;
    logic               taken;
    logic [SP_W-1:0]    sp;
    logic               stack_ovf;
    logic               stack_unf;

    int errors = 0;
    int checks = 0;
    int lat;
    logic tk;
    logic incWithOp;

    pc_branch_seq #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH),
        .RESET_PC    (0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .opcode    (opcode),
        .target    (target),
        .zero_flag (zero_flag),
        .pc_inc    (pc_inc),
        .pc        (pc),
        .done      (done),
        .taken     (taken),
        .sp        (sp),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one op and wait (bounded) for done. Returns at the falling edge
    // where done is high; lat counts falling edges from accept to done.
    task automatic applyStimulus(input logic [7:0] op, input logic [ADDR_W-1:0] tgt,
                                 input logic z, output int latency, output logic tkn);
        int guard;
        guard = 0;
        while (!op_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        op_valid  = 1'b1;
        opcode    = op;
        target    = tgt;
        zero_flag = z;
        pc_inc    = incWithOp;
        @(posedge clock);
        @(negedge clock);
        op_valid = 1'b0;
        pc_inc   = 1'b0;
        latency  = 1;
        while (!done && latency < 10) begin
            @(negedge clock);
            latency++;
        end
        tkn = taken;
        if (!done) checkOutput("done_timeout", {31'd0, done}, 32'd1);
    endtask

    // Hold pc_inc for n idle cycles.
    task automatic pulseInc(input int n);
        pc_inc = 1'b1;
        repeat (n) @(negedge clock);
        pc_inc = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        op_valid  = 1'b0;
        opcode    = 8'h00;
        target    = '0;
        zero_flag = 1'b0;
        pc_inc    = 1'b0;
        incWithOp = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clock);
        checkOutput("rst_pc",       32'(pc), 32'h00);
        checkOutput("rst_sp",       32'(sp), 32'h0);
        checkOutput("rst_done",     32'(done), 32'h0);
        checkOutput("rst_taken",    32'(taken), 32'h0);
        checkOutput("rst_ovf",      32'(stack_ovf), 32'h0);
        checkOutput("rst_unf",      32'(stack_unf), 32'h0);
        checkOutput("rst_ready",    32'(op_ready), 32'h1);
        reset = 1'b1;
        @(negedge clock);

        // ---------------- 1: reset during CALL's LOAD state ----------------
        op_valid = 1'b1; opcode = CALL; target = 8'h55; zero_flag = 1'b0;
        @(posedge clock);              // accept
        @(negedge clock);
        op_valid = 1'b0;
        @(negedge clock);              // now in LOAD with sp=1
        checkOutput("t1_sp_pushed", 32'(sp), 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("t1_async_pc",  32'(pc), 32'h00);
        checkOutput("t1_async_sp",  32'(sp), 32'h0);
        repeat (2) @(negedge clock);
        checkOutput("t1_no_done",   32'(done), 32'h0);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("t1_no_done2",  32'(done), 32'h0);
        pulseInc(3);
        checkOutput("t1_inc3",      32'(pc), 32'h03);

        // ---------------- 2: JMP latency and handshake ----------------
        applyStimulus(JMP, 8'h10, 1'b0, lat, tk);
        checkOutput("t2_setup_pc",  32'(pc), 32'h10);
        applyStimulus(JMP, 8'h40, 1'b0, lat, tk);
        checkOutput("t2_jmp_pc",    32'(pc), 32'h40);
        checkOutput("t2_jmp_lat",   32'(lat), 32'd2);
        checkOutput("t2_jmp_taken", 32'(tk), 32'h1);
        checkOutput("t2_busy",      32'(op_ready), 32'h0);
        @(negedge clock);
        checkOutput("t2_ready",     32'(op_ready), 32'h1);
        checkOutput("t2_done_clr",  32'(done), 32'h0);
        checkOutput("t2_taken_clr", 32'(taken), 32'h0);

        // ---------------- 3: conditional branches, GOTO, NOP ----------------
        applyStimulus(JMP, 8'h05, 1'b0, lat, tk);
        applyStimulus(JZ,  8'h20, 1'b0, lat, tk);
        checkOutput("t3_jz0_pc",    32'(pc), 32'h06);
        checkOutput("t3_jz0_taken", 32'(tk), 32'h0);
        checkOutput("t3_jz0_lat",   32'(lat), 32'd2);
        applyStimulus(JMP, 8'h05, 1'b0, lat, tk);
        applyStimulus(JZ,  8'h20, 1'b1, lat, tk);
        checkOutput("t3_jz1_pc",    32'(pc), 32'h20);
        checkOutput("t3_jz1_taken", 32'(tk), 32'h1);
        applyStimulus(JMP, 8'h05, 1'b0, lat, tk);
        applyStimulus(JNZ, 8'h20, 1'b0, lat, tk);
        checkOutput("t3_jnz0_pc",   32'(pc), 32'h20);
        checkOutput("t3_jnz0_taken",32'(tk), 32'h1);
        applyStimulus(JMP, 8'h05, 1'b0, lat, tk);
        applyStimulus(JNZ, 8'h20, 1'b1, lat, tk);
        checkOutput("t3_jnz1_pc",   32'(pc), 32'h06);
        checkOutput("t3_jnz1_taken",32'(tk), 32'h0);
        applyStimulus(GOTO, 8'h33, 1'b0, lat, tk);
        checkOutput("t3_goto_pc",   32'(pc), 32'h33);
        checkOutput("t3_goto_taken",32'(tk), 32'h1);
        applyStimulus(NOPC, 8'hAA, 1'b1, lat, tk);
        checkOutput("t3_nop_pc",    32'(pc), 32'h34);
        checkOutput("t3_nop_taken", 32'(tk), 32'h0);
        checkOutput("t3_nop_lat",   32'(lat), 32'd2);

        // ---------------- 4: nested CALL / RET ----------------
        applyStimulus(JMP,  8'h10, 1'b0, lat, tk);
        applyStimulus(CALL, 8'h80, 1'b0, lat, tk);
        checkOutput("t4_call1_pc",  32'(pc), 32'h80);
        checkOutput("t4_call1_sp",  32'(sp), 32'h1);
        checkOutput("t4_call1_lat", 32'(lat), 32'd3);
        checkOutput("t4_call1_tk",  32'(tk), 32'h1);
        applyStimulus(CALL, 8'h90, 1'b0, lat, tk);
        checkOutput("t4_call2_pc",  32'(pc), 32'h90);
        checkOutput("t4_call2_sp",  32'(sp), 32'h2);
        applyStimulus(RET,  8'h00, 1'b0, lat, tk);
        checkOutput("t4_ret1_pc",   32'(pc), 32'h81);
        checkOutput("t4_ret1_sp",   32'(sp), 32'h1);
        checkOutput("t4_ret1_lat",  32'(lat), 32'd3);
        checkOutput("t4_ret1_tk",   32'(tk), 32'h1);
        applyStimulus(RET,  8'h00, 1'b0, lat, tk);
        checkOutput("t4_ret2_pc",   32'(pc), 32'h11);
        checkOutput("t4_ret2_sp",   32'(sp), 32'h0);

        // ---------------- 5: overflow / underflow ----------------
        // Return entries become 0x01, 0x21 .. 0x27 (bottom to top).
        applyStimulus(JMP, 8'h00, 1'b0, lat, tk);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(CALL, 8'(8'h20 + i), 1'b0, lat, tk);
        end
        checkOutput("t5_full_sp",   32'(sp), 32'd8);
        checkOutput("t5_full_pc",   32'(pc), 32'h27);
        checkOutput("t5_ovf_pre",   32'(stack_ovf), 32'h0);
        applyStimulus(CALL, 8'h99, 1'b0, lat, tk);
        checkOutput("t5_ovf",       32'(stack_ovf), 32'h1);
        checkOutput("t5_ovf_sp",    32'(sp), 32'd8);
        checkOutput("t5_ovf_pc",    32'(pc), 32'h28);
        checkOutput("t5_ovf_tk",    32'(tk), 32'h0);
        checkOutput("t5_ovf_lat",   32'(lat), 32'd2);
        for (int i = 7; i >= 1; i--) begin
            applyStimulus(RET, 8'h00, 1'b0, lat, tk);
            checkOutput("t5_ret_pc", 32'(pc), 32'h20 + 32'(i));
        end
        applyStimulus(RET, 8'h00, 1'b0, lat, tk);
        checkOutput("t5_ret_bottom",32'(pc), 32'h01);
        checkOutput("t5_empty_sp",  32'(sp), 32'h0);
        checkOutput("t5_unf_pre",   32'(stack_unf), 32'h0);
        applyStimulus(RET, 8'h00, 1'b0, lat, tk);
        checkOutput("t5_unf",       32'(stack_unf), 32'h1);
        checkOutput("t5_unf_pc",    32'(pc), 32'h02);
        checkOutput("t5_unf_sp",    32'(sp), 32'h0);
        checkOutput("t5_unf_tk",    32'(tk), 32'h0);
        checkOutput("t5_ovf_sticky",32'(stack_ovf), 32'h1);

        // ---------------- 6: wrap and accept priority ----------------
        applyStimulus(JMP, 8'hFF, 1'b0, lat, tk);
        @(negedge clock);
        pulseInc(1);
        checkOutput("t6_inc_wrap",  32'(pc), 32'h00);
        applyStimulus(JMP,  8'hFF, 1'b0, lat, tk);
        applyStimulus(CALL, 8'h44, 1'b0, lat, tk);
        checkOutput("t6_call_pc",   32'(pc), 32'h44);
        applyStimulus(RET,  8'h00, 1'b0, lat, tk);
        checkOutput("t6_ret_wrap",  32'(pc), 32'h00);
        incWithOp = 1'b1;
        applyStimulus(8'h00, 8'h00, 1'b0, lat, tk);
        incWithOp = 1'b0;
        checkOutput("t6_op_wins",   32'(pc), 32'h01);
        checkOutput("t6_unf_sticky",32'(stack_unf), 32'h1);

        // Sticky flags drop only on reset.
        reset = 1'b0;
        @(negedge clock);
        checkOutput("end_ovf_clr",  32'(stack_ovf), 32'h0);
        checkOutput("end_unf_clr",  32'(stack_unf), 32'h0);
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit in case something stalls outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
